// File: rtl/note_bank_writer.sv
// Producer side of a two-bank ping-pong buffer. Incoming bytes fill one bank
// while the reader drains the other. Each full bank is handed to the reader
// through bank_full. A flush zero-pads a partial bank to its full depth.
module note_bank_writer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              ram0_we,
  output logic              ram1_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        bank_full,
  input  logic [1:0]        rd_done,
  output logic              err
);

  typedef enum logic [1:0] {StFill, StPad, StCommit} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic              wb_q, wb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        full_q, full_d;
  logic              we0_q, we0_d, we1_q, we1_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              fill_ready;
  logic              transfer;

  // Accept only while filling a bank that the reader does not own.
  assign fill_ready = (state_q == StFill) && !full_q[wb_q];
  assign transfer   = fill_ready && in_valid;
  assign in_ready   = resetn && fill_ready;

  // Next-state, registered write port, and the bank hand-off and release bookkeeping.
  always_comb begin
    state_d = state_q;
    wb_d    = wb_q;
    addr_d  = addr_q;
    full_d  = full_q;
    we0_d   = 1'b0;
    we1_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    // A release of a bank the reader does not hold is a protocol error.
    for (int b = 0; b < 2; b++) begin
      if (rd_done[b]) begin
        if (full_q[b]) full_d[b] = 1'b0;
        else           err_d     = 1'b1;
      end
    end

    unique case (state_q)
      StFill: begin
        if (transfer) begin
          we0_d   = ~wb_q;
          we1_d   = wb_q;
          waddr_d = addr_q;
          wdata_d = in_data;
          addr_d  = addr_q + 1'b1;
          if (addr_q == LastAddr) state_d = StCommit;
          else if (flush)         state_d = StPad;
        end else if (flush && (addr_q != '0)) begin
          state_d = StPad;
        end
      end
      StPad: begin
        we0_d   = ~wb_q;
        we1_d   = wb_q;
        waddr_d = addr_q;
        wdata_d = '0;
        addr_d  = addr_q + 1'b1;
        if (addr_q == LastAddr) state_d = StCommit;
      end
      StCommit: begin
        // The last data strobe is on the bus during this cycle, so the bank is flagged one
        // cycle after that strobe.
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        addr_d       = '0;
        state_d      = StFill;
      end
      default: state_d = StFill;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StFill;
      wb_q    <= 1'b0;
      addr_q  <= '0;
      full_q  <= '0;
      we0_q   <= 1'b0;
      we1_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      we0_q   <= we0_d;
      we1_q   <= we1_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign ram0_we   = we0_q;
  assign ram1_we   = we1_q;
  assign wr_addr   = waddr_q;
  assign wr_data   = wdata_q;
  assign bank_full = full_q;
  assign err       = err_q;

endmodule
